// File: rtl/lamp_serializer.sv
`default_nettype none
// ============================================================================
// lamp_serializer : ships the parallel lamp vector to a SIPO lamp-driver chain
//                   over sdo/sclk/latch whenever it differs from what is latched
// Revision        : 1.0
// ============================================================================
module lamp_serializer #(
    parameter int MX_LP   = 16,
    parameter int SCK_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MX_LP-1:0] lp_in,
    input  logic             clr_ovf,
    output logic             sdo,
    output logic             sclk,
    output logic             latch,
    output logic             busy,
    output logic             ovf,
    output logic [7:0]       frame_cnt
);

    localparam int BIT_W = (MX_LP > 1) ? $clog2(MX_LP) : 1;
    localparam int DIV_W = $clog2(2 * SCK_DIV);

    localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(MX_LP - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * SCK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [MX_LP-1:0] shadow, shadow_n;
    logic [MX_LP-1:0] last_sent, last_sent_n;
    logic [MX_LP-1:0] lp_q;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_n;
    logic [DIV_W-1:0] div_cnt, div_cnt_n;
    logic             pending, pending_n;
    logic             sdo_n, sclk_n, latch_n, busy_n, ovf_n;
    logic [7:0]       frame_cnt_n;
    logic             lp_chg;
    logic             ovf_set;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shadow    <= '0;
            last_sent <= '0;
            lp_q      <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            pending   <= 1'b0;
            sdo       <= 1'b0;
            sclk      <= 1'b0;
            latch     <= 1'b0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            state     <= state_n;
            shadow    <= shadow_n;
            last_sent <= last_sent_n;
            lp_q      <= lp_in;
            bit_cnt   <= bit_cnt_n;
            div_cnt   <= div_cnt_n;
            pending   <= pending_n;
            sdo       <= sdo_n;
            sclk      <= sclk_n;
            latch     <= latch_n;
            busy      <= busy_n;
            ovf       <= ovf_n;
            frame_cnt <= frame_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        shadow_n    = shadow;
        last_sent_n = last_sent;
        bit_cnt_n   = bit_cnt;
        div_cnt_n   = div_cnt;
        pending_n   = pending;
        sdo_n       = sdo;
        sclk_n      = sclk;
        latch_n     = latch;
        busy_n      = busy;
        ovf_n       = ovf;
        frame_cnt_n = frame_cnt;
        ovf_set     = 1'b0;

        // Input movement while a frame is on the wire: second change loses a pattern
        lp_chg = busy && (lp_in != lp_q);
        if (lp_chg) begin
            if (pending) begin
                ovf_set = 1'b1;
            end
            pending_n = 1'b1;
        end
        if (clr_ovf) begin
            ovf_n = 1'b0;
        end
        if (ovf_set) begin
            ovf_n = 1'b1;
        end

        case (state)
            IDLE: begin
                if (lp_in != last_sent) begin
                    shadow_n  = lp_in;
                    sdo_n     = lp_in[MX_LP-1];
                    bit_cnt_n = BIT_TOP;
                    div_cnt_n = '0;
                    sclk_n    = 1'b0;
                    busy_n    = 1'b1;
                    pending_n = 1'b0;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                div_cnt_n = div_cnt + 1'b1;
                if (div_cnt == DIV_HALF) begin
                    sclk_n = 1'b1;
                end
                if (div_cnt == DIV_LAST) begin
                    sclk_n    = 1'b0;
                    div_cnt_n = '0;
                    if (bit_cnt != '0) begin
                        bit_cnt_n = bit_cnt - 1'b1;
                        sdo_n     = shadow[bit_cnt - 1'b1];
                    end else begin
                        latch_n = 1'b1;
                        state_n = LATCH;
                    end
                end
            end
            LATCH: begin
                div_cnt_n = div_cnt + 1'b1;
                if (div_cnt == DIV_HALF) begin
                    div_cnt_n   = '0;
                    latch_n     = 1'b0;
                    busy_n      = 1'b0;
                    last_sent_n = shadow;
                    frame_cnt_n = frame_cnt + 8'd1;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lamp_serializer.sv
`default_nettype none
// ============================================================================
// tb_lamp_serializer : directed and randomized checks of lamp_serializer
// Revision           : 1.0
// ============================================================================
module tb_lamp_serializer;

    localparam int N_RND = 2500;
    localparam int L_A   = 66;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clr_ovf, rst_n_b, clr_ovf_b;
    logic [15:0] lp_in, lp_in_b;
    logic        sdo, sclk, latch, busy, ovf;
    logic        sdo_b, sclk_b, latch_b, busy_b, ovf_b;
    logic [7:0]  frame_cnt, frame_cnt_b;

    lamp_serializer #(.MX_LP(16), .SCK_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .lp_in(lp_in), .clr_ovf(clr_ovf),
        .sdo(sdo), .sclk(sclk), .latch(latch), .busy(busy), .ovf(ovf),
        .frame_cnt(frame_cnt)
    );

    lamp_serializer #(.MX_LP(16), .SCK_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .lp_in(lp_in_b), .clr_ovf(clr_ovf_b),
        .sdo(sdo_b), .sclk(sclk_b), .latch(latch_b), .busy(busy_b), .ovf(ovf_b),
        .frame_cnt(frame_cnt_b)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame capture on the wire side: bits taken at sclk rise, frame closed at latch rise
    logic        ps_a = 1'b0, pl_a = 1'b0, pb_a = 1'b0;
    logic        ps_b = 1'b0, pl_b = 1'b0, pb_b = 1'b0;
    logic [15:0] cur_a = '0, cur_b = '0;
    int          nb_a = 0, run_a = 0, nb_b = 0, run_b = 0;
    int          latch_rises_a = 0, sclk_hi_a = 0, busy_hi_a = 0;
    logic [31:0] frames_a[$], frames_b[$];
    int          blen_a[$], blen_b[$];

    initial forever begin
        @(negedge clk);
        if (busy && !pb_a) begin cur_a = '0; nb_a = 0; run_a = 0; end
        if (busy) begin run_a++; busy_hi_a++; end
        if (!busy && pb_a) blen_a.push_back(run_a);
        if (sclk) sclk_hi_a++;
        if (sclk && !ps_a) begin cur_a = {cur_a[14:0], sdo}; nb_a++; end
        if (latch && !pl_a) begin latch_rises_a++; frames_a.push_back({16'(nb_a), cur_a}); end
        ps_a = sclk; pl_a = latch; pb_a = busy;

        if (busy_b && !pb_b) begin cur_b = '0; nb_b = 0; run_b = 0; end
        if (busy_b) run_b++;
        if (!busy_b && pb_b) blen_b.push_back(run_b);
        if (sclk_b && !ps_b) begin cur_b = {cur_b[14:0], sdo_b}; nb_b++; end
        if (latch_b && !pl_b) frames_b.push_back({16'(nb_b), cur_b});
        ps_b = sclk_b; pl_b = latch_b; pb_b = busy_b;
    end

    task automatic clr_mon();
        frames_a.delete(); blen_a.delete();
        frames_b.delete(); blen_b.delete();
        latch_rises_a = 0; sclk_hi_a = 0; busy_hi_a = 0;
    endtask

    logic [15:0] seq [N_RND];
    logic [15:0] exp_q[$];
    logic [15:0] v, last_v;
    logic        exp_ovf;
    int          hold, k, chg;

    initial begin
        rst_n = 1'b0; rst_n_b = 1'b0; clr_ovf = 1'b0; clr_ovf_b = 1'b0;
        lp_in = '0; lp_in_b = '0;

        // Reset state, then a long quiet idle
        step(3);
        chk("reset_outputs", {sdo, sclk, latch, busy, ovf, frame_cnt}, 0);
        chk("reset_outputs_b", {sdo_b, sclk_b, latch_b, busy_b, ovf_b, frame_cnt_b}, 0);
        rst_n = 1'b1; rst_n_b = 1'b1;
        clr_mon();
        step(200);
        chk("idle_busy_cycles", busy_hi_a, 0);
        chk("idle_sclk_cycles", sclk_hi_a, 0);
        chk("idle_latch_rises", latch_rises_a, 0);
        chk("idle_frame_cnt", frame_cnt, 0);

        // Single frame 0x0001 with exact timing
        lp_in = 16'h0001; step(1);
        chk("f1_busy_start", busy, 1);
        chk("f1_first_sdo", sdo, 0);
        step(63);
        chk("f1_latch_e63", latch, 0);
        step(1);
        chk("f1_latch_e64", {latch, busy}, 2'b11);
        step(1);
        chk("f1_latch_e65", {latch, busy}, 2'b11);
        step(1);
        chk("f1_done_e66", {latch, busy}, 2'b00);
        step(60);
        chk("f1_frame_cnt", frame_cnt, 1);
        chk("f1_frames", frames_a.size(), 1);
        if (frames_a.size() > 0) chk("f1_value", frames_a[0], {16'd16, 16'h0001});
        chk("f1_busy_len", (blen_a.size() == 1) ? blen_a[0] : -1, 66);
        chk("f1_sclk_high", sclk_hi_a, 32);

        // Flasher walk; clr_ovf collides with the overflow event
        rst_n = 1'b0; lp_in = '0; step(2);
        rst_n = 1'b1; clr_mon();
        lp_in = 16'h0001; step(1);
        lp_in = 16'h0003; step(1);
        lp_in = 16'h0007; clr_ovf = 1'b1; step(1);
        clr_ovf = 1'b0;
        chk("walk_ovf_setwins", ovf, 1);
        step(64);
        chk("walk_gap_idle", busy, 0);
        step(1);
        chk("walk_f2_start", busy, 1);
        step(100);
        chk("walk_frame_cnt", frame_cnt, 2);
        chk("walk_frames", frames_a.size(), 2);
        if (frames_a.size() == 2) begin
            chk("walk_f1_value", frames_a[0], {16'd16, 16'h0001});
            chk("walk_f2_value", frames_a[1], {16'd16, 16'h0007});
        end
        chk("walk_ovf_sticky", ovf, 1);

        // SCK_DIV=1 instance: overflow, then 0xA5C3, then clear ovf
        lp_in_b = 16'h0001; step(1);
        lp_in_b = 16'h0003; step(1);
        lp_in_b = 16'h0007; step(1);
        chk("b_walk_ovf", ovf_b, 1);
        step(80);
        lp_in_b = 16'hA5C3; step(1);
        chk("b_busy_start", busy_b, 1);
        step(40);
        chk("b_ovf_before_clr", ovf_b, 1);
        clr_ovf_b = 1'b1; step(1); clr_ovf_b = 1'b0;
        chk("b_clr_ovf", ovf_b, 0);
        chk("b_frame_cnt", frame_cnt_b, 3);
        chk("b_frames", frames_b.size(), 3);
        if (frames_b.size() == 3) chk("b_a5c3_value", frames_b[2], {16'd16, 16'hA5C3});
        chk("b_busy_len", (blen_b.size() == 3) ? blen_b[2] : -1, 33);

        // Reset in the middle of bit 7
        clr_mon();
        lp_in = 16'hFFFF; step(1);
        step(33);
        chk("mid_shift_busy", busy, 1);
        rst_n = 1'b0; step(1);
        chk("mid_reset_outputs", {sdo, sclk, latch, busy, ovf, frame_cnt}, 0);
        step(1);
        chk("mid_no_latch", latch_rises_a, 0);
        rst_n = 1'b1; clr_mon();
        step(1);
        chk("mid_restart_busy", busy, 1);
        step(80);
        chk("mid_latch_rises", latch_rises_a, 1);
        chk("mid_frames", frames_a.size(), 1);
        if (frames_a.size() == 1) chk("mid_value", frames_a[0], {16'd16, 16'hFFFF});
        chk("mid_frame_cnt", frame_cnt, 1);

        // 256 alternating frames wrap the counter
        rst_n = 1'b0; lp_in = '0; step(2);
        rst_n = 1'b1; clr_mon();
        for (int i = 0; i < 256; i++) begin
            lp_in = (i % 2 == 0) ? 16'h0001 : 16'h0000;
            step(68);
        end
        step(5);
        chk("wrap_frame_cnt", frame_cnt, 0);
        chk("wrap_frames", frames_a.size(), 256);
        for (int i = 0; i < 256 && i < frames_a.size(); i++)
            chk("wrap_value", frames_a[i], {16'd16, (i % 2 == 0) ? 16'h0001 : 16'h0000});

        // Randomized lamp activity against a transaction-level model
        v = '0; hold = 0;
        for (int i = 0; i < N_RND; i++) begin
            if (i < N_RND - 200 && hold == 0) begin
                v    = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
                hold = $urandom_range(1, 90);
            end
            if (hold > 0) hold--;
            seq[i] = v;
        end
        rst_n = 1'b0; lp_in = '0; step(2);
        rst_n = 1'b1; clr_mon();
        for (int i = 0; i < N_RND; i++) begin
            lp_in = seq[i];
            step(1);
        end

        // A frame starts on any edge where the input differs from the last
        // latched value; it occupies L_A edges and loses a value on 2+ changes.
        exp_q.delete(); last_v = '0; exp_ovf = 1'b0; k = 0;
        while (k < N_RND) begin
            if (seq[k] != last_v) begin
                exp_q.push_back(seq[k]);
                chg = 0;
                for (int j = k + 1; j <= k + L_A && j < N_RND; j++)
                    if (seq[j] != seq[j-1]) chg++;
                if (chg >= 2) exp_ovf = 1'b1;
                last_v = seq[k];
                k = k + L_A + 1;
            end else begin
                k++;
            end
        end
        chk("rand_frames", frames_a.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < frames_a.size(); i++)
            chk("rand_value", frames_a[i], {16'd16, exp_q[i]});
        chk("rand_frame_cnt", frame_cnt, exp_q.size() % 256);
        chk("rand_ovf", ovf, exp_ovf);
        for (int i = 0; i < blen_a.size(); i++)
            chk("rand_busy_len", blen_a[i], L_A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lamp_serializer.md
Name: lamp_serializer

Overview:
- Downstream of the bound flasher: consumes the 16-bit parallel lamp vector and drives it to an external 16-bit serial-in/parallel-out lamp driver chain over a 3-wire interface (sdo, sclk, latch).
- Transmits only when the lamp vector differs from the last value latched into the driver, so the external lamps always mirror the flasher output with bounded delay.
- Reports frames sent and dropped intermediate patterns.

Parameters:
- MX_LP, 16, number of lamps; bits per frame.
- SCK_DIV, 2, clk cycles per sclk phase (low phase and high phase each SCK_DIV cycles); legal range 1..15.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst_n, input, 1, synchronous active-low reset, sampled on rising clk.
- lp_in, input, MX_LP, lamp vector from the flasher, registered there.
- clr_ovf, input, 1, single-cycle pulse; clears ovf.
- sdo, output, 1, serial data, MSB (lamp MX_LP-1) first.
- sclk, output, 1, serial clock; driver samples sdo on sclk rising edge.
- latch, output, 1, high for SCK_DIV cycles after the last bit; driver transfers its shift register to its outputs.
- busy, output, 1, high while a frame (shift plus latch) is in progress.
- ovf, output, 1, sticky: a lamp pattern was overwritten before it was transmitted.
- frame_cnt, output, 8, completed frames, wraps 255->0.

Behaviour:
- Reset (rst_n=0 at an edge): sdo=0, sclk=0, latch=0, busy=0, ovf=0, frame_cnt=0, FSM=IDLE, last_sent=0, lp_q=0, pending=0. Reset mid-frame aborts immediately; no partial latch pulse.
- Internal registers: shadow (frame being sent), last_sent (last latched value), lp_q (lp_in delayed 1 cycle), bit_cnt (0..MX_LP-1), div_cnt (0..2*SCK_DIV-1), pending.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE:
  - If lp_in != last_sent at an edge: shadow<=lp_in, sdo<=lp_in[MX_LP-1], bit_cnt<=MX_LP-1, div_cnt<=0, sclk<=0, busy<=1, pending<=0, go to SHIFT.
  - Otherwise hold with all outputs idle (sdo keeps its last value).
- SHIFT:
  - div_cnt increments every cycle.
  - sclk<=1 when div_cnt==SCK_DIV-1, so sclk is high for bit cycles SCK_DIV..2*SCK_DIV-1.
  - At div_cnt==2*SCK_DIV-1:
    - If bit_cnt!=0: sclk<=0, div_cnt<=0, bit_cnt<=bit_cnt-1, sdo<=shadow[bit_cnt-1].
    - If bit_cnt==0: sclk<=0, latch<=1, div_cnt<=0, go to LATCH.
  - sdo is stable for the whole bit, including the sclk rising edge.
- LATCH:
  - latch stays high SCK_DIV cycles.
  - At the last latch cycle: latch<=0, busy<=0, last_sent<=shadow, frame_cnt<=frame_cnt+1, go to IDLE.
- Timing with defaults: busy high exactly MX_LP*2*SCK_DIV + SCK_DIV = 66 cycles.
- Latency: lp_in change seen at edge E0 -> busy/first sdo at E0 -> latch falls at E0+66.
- Back-to-back frames: if lp_in != last_sent on the cycle after LATCH exits, the next frame starts; minimum one IDLE cycle between frames.
- Change tracking: lp_q<=lp_in every cycle. While busy, lp_in != lp_q marks a change.
  - First change in a frame sets pending.
  - A further change while pending=1 sets ovf (intermediate value lost).
- Only the lp_in value present when returning to IDLE is sent next; lp_in changes never disturb shadow mid-frame.
- lp_in returning to last_sent during a frame: no new frame is started; the pending/ovf rules above still apply.
- ovf: sticky until clr_ovf=1. If clr_ovf and a new overflow event occur in the same cycle, set wins.
- frame_cnt is not cleared by clr_ovf.

Test Plan:
- Reset, lp_in=16'h0000 held 200 cycles -> busy never rises, sclk/latch stay 0, frame_cnt=0.
- lp_in 0->16'h0001 at E0 ->
  - busy high E0..E0+65.
  - 16 sclk rising edges, sampled sdo sequence fifteen 0s then 1.
  - latch high 2 cycles at E0+64..E0+65.
  - frame_cnt=1, no further frame.
- Flasher walk 16'h0001->16'h0003->16'h0007, one cycle apart ->
  - Frame 1 sends 0x0001.
  - ovf=1 (0x0003 lost).
  - Frame 2 starts one cycle after frame 1 and sends 0x0007.
  - frame_cnt=2.
- Drive 16'hA5C3 with SCK_DIV=1 -> sdo bitstream 1010010111000011, busy 33 cycles; clr_ovf pulse clears a previously set ovf.
- rst_n low mid-SHIFT (bit 7) with lp_in=16'hFFFF ->
  - Next edge: all outputs 0, no latch pulse.
  - After release, a full frame 0xFFFF is sent because last_sent=0.
- 256 alternating frames 0x0001/0x0000 -> frame_cnt wraps to 0, each frame sends the correct value.
